alu_fu: RTL

- Pipelined integer ALU functional unit for the Tomasulo core, parametrised in data width, tag width and latency.
- Accepts one operation per cycle from the ALU reservation station through a valid/ready issue handshake and carries the ROB tag alongside the operation.
- Presents each result on the common data bus (CDB) through a valid/ready handshake and stalls in place when the CDB arbiter withholds its grant.
- Successor to the single-cycle combinational ALU: adds SRA, SLTU and PASS_B, configurable pipeline depth, back-pressure and bubble collapsing.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 51 +++++
 rtl/alu_fu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU functional unit.
//   OP_W      - opcode width
//   alu_op_e  - the eleven defined operation codes; codes 1011-1111 are
//               unassigned and produce a zero result.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_AND    = 4'b0010,
    OP_OR     = 4'b0011,
    OP_XOR    = 4'b0100,
    OP_SLL    = 4'b0101,
    OP_SRL    = 4'b0110,
    OP_SLT    = 4'b0111,
    OP_SRA    = 4'b1000,
    OP_SLTU   = 4'b1001,
    OP_PASS_B = 4'b1010
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
// Ports:
//   op     [OP_W-1:0] operation code (alu_op_e encoding)
//   a      [XLEN-1:0] operand A
//   b      [XLEN-1:0] operand B, or shift amount in its low $clog2(XLEN) bits
//   result [XLEN-1:0] operation result
//   zero              high when result is all zeros
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SH_W = $clog2(XLEN);

  // Only the low SH_W bits of b form the shift amount.
  logic [SH_W-1:0] shamt;
  logic            lt_signed;
  logic            lt_unsigned;

  assign shamt       = b[SH_W-1:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:    result = a + b;
      OP_SUB:    result = a - b;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_SLL:    result = a << shamt;
      OP_SRL:    result = a >> shamt;
      OP_SLT:    result = {{(XLEN-1){1'b0}}, lt_signed};
      OP_SRA:    result = $signed(a) >>> shamt;
      OP_SLTU:   result = {{(XLEN-1){1'b0}}, lt_unsigned};
      OP_PASS_B: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_fu.sv
// alu_fu: pipelined integer ALU functional unit for the Tomasulo core.
// The result is computed combinationally from the issue inputs and captured
// in stage 1; later stages only carry {result, zero, tag}. The CDB outputs
// come straight from the last stage register.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             kill all in-flight operations (only when the
//                     ALU_FU_FLUSH_EN macro is defined)
//   issue_valid/ready issue handshake from the reservation station
//   issue_op/a/b/tag  operation, operands and destination ROB tag
//   cdb_valid/ready   result handshake towards the CDB arbiter
//   cdb_result/zero/tag result, result==0 flag, ROB tag
//   busy              any stage holds a valid operation
// Optional build macro: ALU_FU_FLUSH_EN adds the flush port.
module alu_fu
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ALU_FU_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [XLEN-1:0]  issue_a,
  input  logic [XLEN-1:0]  issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [XLEN-1:0]  cdb_result,
  output logic             cdb_zero,
  output logic [TAG_W-1:0] cdb_tag,
  output logic             busy
);

  // Handshakes: a transfer happens at a rising edge when valid && ready.
  // Producers hold valid and payload until that edge; ready never depends on
  // the valid of the same interface; while cdb_valid is high and cdb_ready
  // low, cdb_result/cdb_zero/cdb_tag stay unchanged.

  logic kill;
`ifdef ALU_FU_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  logic [STAGES-1:0] stg_v;
  logic [XLEN-1:0]   stg_res  [STAGES];
  logic              stg_zero [STAGES];
  logic [TAG_W-1:0]  stg_tag  [STAGES];

  logic [STAGES-1:0] empty_v;
  logic [STAGES-1:0] adv;

  logic [XLEN-1:0]   core_res;
  logic              core_zero;

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .op     (issue_op),
    .a      (issue_a),
    .b      (issue_b),
    .result (core_res),
    .zero   (core_zero)
  );

  // Stage k advances when the CDB accepts or any stage from k to the end is
  // empty: the hole lets everything upstream of it shift by one, which is
  // what collapses bubbles. Written as a flat OR to avoid a ripple loop.
  assign empty_v = ~stg_v;

  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = cdb_ready || (|(empty_v >> k));
    end
  end

  assign issue_ready = adv[0] && !kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stg_res[k]  <= '0;
        stg_zero[k] <= 1'b0;
        stg_tag[k]  <= '0;
      end
    end else if (kill) begin
      // Only the valid bits are cleared; data keeps stale values.
      stg_v <= '0;
    end else begin
      if (adv[0]) begin
        stg_v[0] <= issue_valid;
      end
      if (issue_valid && issue_ready) begin
        stg_res[0]  <= core_res;
        stg_zero[0] <= core_zero;
        stg_tag[0]  <= issue_tag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          stg_v[k] <= stg_v[k-1];
          if (stg_v[k-1]) begin
            stg_res[k]  <= stg_res[k-1];
            stg_zero[k] <= stg_zero[k-1];
            stg_tag[k]  <= stg_tag[k-1];
          end
        end
      end
    end
  end

  assign cdb_valid  = stg_v[STAGES-1] && !kill;
  assign cdb_result = stg_res[STAGES-1];
  assign cdb_zero   = stg_zero[STAGES-1];
  assign cdb_tag    = stg_tag[STAGES-1];
  assign busy       = |stg_v;

endmodule
